// File: rtl/useq_ctrl.sv
// useq_ctrl: microsequencer for the microcoded datapath.
// Owns the micro-program counter, a small return stack and the
// IDLE/RUN/WAIT/HALT control state. All outputs are registered.
module useq_ctrl #(
  parameter int AW = 5,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    br_type,
  input  logic [1:0]    cond_sel,
  input  logic [AW-1:0] br_addr,
  input  logic          flag_z,
  input  logic          flag_c,
  input  logic          flag_n,
  input  logic          ext_ready,
  output logic [AW-1:0] upc,
  output logic          busy,
  output logic          done,
  output logic          stack_err
);

  // Stack index width and occupancy width (occupancy spans 0..SD inclusive)
  localparam int IW = (SD > 1) ? $clog2(SD) : 1;
  localparam int PW = IW + 1;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JC   = 3'd2;
  localparam logic [2:0] OP_JNC  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_WAIT = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic [PW-1:0] sp_q, sp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Return stack storage; contents are deliberately left unreset
  logic [AW-1:0] stk_q [SD];

  logic          push_en;
  logic [AW-1:0] upc_inc;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  logic          stk_full;
  logic          stk_empty;
  logic          cond;

  // Wrapping increment; a return address of 2^AW-1 + 1 naturally stores as 0
  assign upc_inc   = upc_q + AW'(1);
  assign push_idx  = sp_q[IW-1:0];
  assign pop_idx   = sp_q[IW-1:0] - IW'(1);
  assign stk_full  = (sp_q == PW'(SD));
  assign stk_empty = (sp_q == '0);

  // Select the branch condition from the datapath flags
  always_comb begin
    cond = 1'b1;
    unique case (cond_sel)
      2'd0:    cond = flag_z;
      2'd1:    cond = flag_c;
      2'd2:    cond = flag_n;
      default: cond = 1'b1;
    endcase
  end

  // Next-state, next-upc and stack pointer decision for the coming edge
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        upc_d = '0;
        if (start) begin
          state_d = S_RUN;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end

      S_RUN: begin
        unique case (br_type)
          OP_NEXT: upc_d = upc_inc;
          OP_JMP:  upc_d = br_addr;
          OP_JC:   upc_d = cond ? br_addr : upc_inc;
          OP_JNC:  upc_d = cond ? upc_inc : br_addr;
          OP_CALL: begin
            if (stk_full) begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + PW'(1);
              upc_d   = br_addr;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              sp_d  = sp_q - PW'(1);
              upc_d = stk_q[pop_idx];
            end
          end
          OP_WAIT: begin
            if (ext_ready) upc_d = upc_inc;
            else           state_d = S_WAIT;
          end
          default: state_d = S_HALT;
        endcase
      end

      // Sequencing fields are ignored while stalled
      S_WAIT: begin
        if (ext_ready) begin
          upc_d   = upc_inc;
          state_d = S_RUN;
        end
      end

      default: begin
        if (start) begin
          state_d = S_RUN;
          upc_d   = '0;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_WAIT);
    done_d = (state_d == S_HALT);
  end

  // Control state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      sp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      sp_q    <= sp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Return-address write on a successful CALL
  always_ff @(posedge clk) begin
    if (push_en) stk_q[push_idx] <= upc_inc;
  end

  assign upc       = upc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stack_err = err_q;

endmodule

// File: doc/useq_ctrl.md
# useq_ctrl

Microsequencer controller for the proj2 microcoded datapath. It owns the 5-bit micro-program counter and decides each cycle whether to increment, branch, call, return, stall or halt. The decision comes from the current microinstruction's sequencing fields and the datapath status flags. It sits between the microcode ROM (addressed by `upc`, read combinationally) and the datapath, and provides start/busy/done handshaking to the top-level controller.

## Interface
Parameters:
- `AW`, 5: micro-address width; `upc` wraps modulo 2^AW.
- `SD`, 4: return-stack depth (entries); power of two, ≥2.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution at address 0; honoured only in IDLE or HALT.
- `br_type`  in  3  sequencing op of current microinstruction: 0 NEXT, 1 JMP, 2 JC (jump if cond), 3 JNC (jump if !cond), 4 CALL, 5 RET, 6 WAIT, 7 HALT.
- `cond_sel`  in  2  condition: 0 `flag_z`, 1 `flag_c`, 2 `flag_n`, 3 constant true.
- `br_addr`  in  AW  branch/call target.
- `flag_z`, `flag_c`, `flag_n`  in  1 each  datapath status flags.
- `ext_ready`  in  1  releases a WAIT.
- `upc`  out  AW  current micro-address (ROM address).
- `busy`  out  1  high in RUN or WAIT.
- `done`  out  1  high while in HALT.
- `stack_err`  out  1  sticky error: CALL with the stack full, or RET with the stack empty.

## Operation
- States: IDLE, RUN, WAIT, HALT.
- IDLE: `upc`=0, outputs low; `start` → RUN. `upc` stays 0, so the microinstruction at 0 executes on the first RUN cycle.
- RUN: on each edge, execute the microinstruction at `upc`:
  - NEXT: `upc`+1.
  - JMP: `br_addr`.
  - JC / JNC: `br_addr` if cond / !cond, else `upc`+1.
  - CALL: push `upc`+1, then `br_addr`. If the stack is full: no push, set `stack_err`, go to HALT, `upc` holds.
  - RET: pop into `upc`. If the stack is empty: set `stack_err`, go to HALT, `upc` holds.
  - WAIT: if `ext_ready`, `upc`+1 and stay in RUN; else go to WAIT, `upc` holds.
  - HALT: go to HALT, `upc` holds.
- WAIT: `upc` holds; the sequencing fields are ignored. When `ext_ready` is seen, `upc`+1 and return to RUN.
- HALT: `done`=1 and `upc` holds. `start` → RUN with `upc`=0, stack pointer cleared, `stack_err` cleared.
- Arithmetic: `upc`+1 is modulo 2^AW (31+1 → 0). A pushed return address of 31+1 is stored as 0.
- Stack: LIFO holding SD entries and an occupancy count from 0 to SD. Stack contents are not reset; only the pointer is.
- `start` is ignored in RUN and WAIT.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE, `upc`=0, stack pointer 0, `busy`=0, `done`=0, `stack_err`=0. Takes effect immediately, mid-instruction included. The first edge with `reset_n`=1 evaluates IDLE.
- Throughput: one microinstruction per cycle in RUN; no branch penalty.
- Sampling: `br_type`, `cond_sel`, `br_addr`, flags and `ext_ready` are sampled at the same edge that updates `upc`. They must be stable one setup time before that edge.
- Outputs are registered (Moore). `busy` and `done` change on the edge that enters or leaves their states.
- `start` to first instruction: 1 edge (IDLE→RUN). The ROM output at address 0 executes on the next edge.
- WAIT release latency: `ext_ready` sampled high on edge k → `upc`+1 visible after edge k.

## Test plan
- Reset/sequence: hold `reset_n`=0 mid-RUN at `upc`=7 → `upc`=0, IDLE, all outputs 0 immediately. Then pulse `start` with all-NEXT microcode → `upc` 0,1,2,…,31,0 and `busy`=1 throughout.
- Conditional branch: at `upc`=3, JC `cond_sel`=0 `br_addr`=20. With `flag_z`=1 → `upc`=20; with `flag_z`=0 → `upc`=4. Repeat JNC with `flag_c` for the inverse result. `cond_sel`=3 always jumps.
- Call/return nesting: CALL 10 at 2, CALL 15 at 11, RET at 15, RET at 12 → `upc` sequence 2,10,11,15,12,3. Stack empty at the end, `stack_err`=0.
- Stack faults: five nested CALLs with SD=4 → fifth sets `stack_err`=1, `done`=1, `upc` holds at the caller. After `start` from HALT → `upc`=0, `stack_err`=0. A RET from reset-empty → `stack_err`=1, HALT.
- WAIT handshake: WAIT at 6, `ext_ready`=0 for 3 cycles → `upc`=6, state WAIT, `busy`=1. `ext_ready`=1 → `upc`=7. Also WAIT with `ext_ready` already high → 6→7 with no stall.
- HALT/restart: HALT at 9 → `done`=1, `busy`=0, `upc`=9 held. `start` during RUN is ignored. `start` in HALT → `upc`=0, RUN.
